// File: rtl/simd_alu_sequencer_if.sv
// Bundles the operand/result handshakes and the ALU side-channel of the SIMD ALU sequencer.
// The slave modport is the sequencer. The master modport is the pipeline control and ALU that surround it.
interface simd_alu_sequencer_if #(
  parameter int unsigned WORDS  = 4,
  parameter int unsigned WORD_W = 32
);
  logic                      in_valid;
  logic                      in_ready;
  logic [WORDS*WORD_W-1:0]   in_a;
  logic [WORDS*WORD_W-1:0]   in_b;
  logic [1:0]                in_op;
  logic [WORDS-1:0]          in_mask;
  logic                      out_valid;
  logic                      out_ready;
  logic [WORDS*WORD_W-1:0]   out_result;
  logic                      busy;
  logic [WORD_W-1:0]         alu_a;
  logic [WORD_W-1:0]         alu_b;
  logic [1:0]                alu_select;
  logic [WORD_W-1:0]         alu_result;

  modport master (
    output in_valid, in_a, in_b, in_op, in_mask, out_ready, alu_result,
    input  in_ready, out_valid, out_result, busy, alu_a, alu_b, alu_select
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_mask, out_ready, alu_result,
    output in_ready, out_valid, out_result, busy, alu_a, alu_b, alu_select
  );
endinterface

// File: rtl/simd_alu_sequencer.sv
// Splits one wide AES state operation into WORD_W-bit beats through a shared combinational SIMD ALU.
// It collects the per-word results into a held, handshaked result.
module simd_alu_sequencer #(
  parameter int unsigned WORDS  = 4,
  parameter int unsigned WORD_W = 32
) (
  input logic                   clk,
  input logic                   rst,
  simd_alu_sequencer_if.slave   bus
);
  localparam int unsigned BW = $clog2(WORDS);
  localparam int unsigned VW = WORDS * WORD_W;
  localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [VW-1:0]     a_q, a_d;
  logic [VW-1:0]     b_q, b_d;
  logic [VW-1:0]     res_q, res_d;
  logic [1:0]        op_q, op_d;
  logic [WORDS-1:0]  mask_q, mask_d;

  logic [WORD_W-1:0] a_word;
  logic [WORD_W-1:0] b_word;
  logic              mask_bit;

  always_comb begin
    a_word   = '0;
    b_word   = '0;
    mask_bit = 1'b0;
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (beat_q == k[BW-1:0]) begin
        a_word   = a_q[k*WORD_W +: WORD_W];
        b_word   = b_q[k*WORD_W +: WORD_W];
        mask_bit = mask_q[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    mask_d  = mask_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          op_d    = bus.in_op;
          mask_d  = bus.in_mask;
          beat_d  = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Masked-off words still consume their beat so latency never depends on the mask
        for (int unsigned k = 0; k < WORDS; k++) begin
          if (beat_q == k[BW-1:0]) begin
            res_d[k*WORD_W +: WORD_W] = mask_bit ? bus.alu_result : a_word;
          end
        end
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = S_DONE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      mask_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      res_q   <= res_d;
    end
  end

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.out_result = res_q;
  assign bus.alu_a      = (state_q == S_ISSUE) ? a_word : '0;
  assign bus.alu_b      = (state_q == S_ISSUE) ? b_word : '0;
  assign bus.alu_select = (state_q == S_ISSUE) ? op_q   : '0;
endmodule
